// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: funct codes for the ALU/MDU decode, MDU state
// encoding, and the sign helpers used by the multiply/divide unit.
package mips_pkg;

  localparam int NB_WORD = 32;

  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIX  = 2'd2
  } mdu_state_t;

  // Two's-complement magnitude; 0x80000000 maps to itself, which is the
  // correct unsigned magnitude 2^31.
  function automatic logic [NB_WORD-1:0] abs32(input logic [NB_WORD-1:0] x);
    return x[NB_WORD-1] ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [2*NB_WORD-1:0] neg64(input logic [2*NB_WORD-1:0] x);
    return ~x + 1'b1;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Operand/control bundle between the EX stage and the multiply/divide unit.
interface mult_div_unit_if #(
  parameter int NB_DATA    = 32,
  parameter int NB_CONTROL = 6
);
  logic                  i_start;
  logic                  i_flush;
  logic [NB_CONTROL-1:0] i_control;
  logic [NB_DATA-1:0]    i_op_a;
  logic [NB_DATA-1:0]    i_op_b;
  logic [NB_DATA-1:0]    o_hi;
  logic [NB_DATA-1:0]    o_lo;
  logic                  o_busy;
  logic                  o_done;

  modport master (
    output i_start, i_flush, i_control, i_op_a, i_op_b,
    input  o_hi, o_lo, o_busy, o_done
  );

  modport slave (
    input  i_start, i_flush, i_control, i_op_a, i_op_b,
    output o_hi, o_lo, o_busy, o_done
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning HI/LO: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, sign fix-up in a final cycle.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int NB_DATA    = 32,
  parameter int NB_CONTROL = 6,
  parameter int NB_COUNT   = 6
) (
  input  logic           i_clk,
  input  logic           i_rst,
  mult_div_unit_if.slave bus
);

  localparam int NB_ACC = 2 * NB_DATA;
  localparam logic [NB_COUNT-1:0] LAST_COUNT = NB_COUNT'(NB_DATA - 1);

  mdu_state_t          state;
  logic [NB_COUNT-1:0] count;
  logic [NB_DATA-1:0]  hi_q;
  logic [NB_DATA-1:0]  lo_q;
  logic                done_q;

  // op mirrors funct[1:0] of the accepted op: bit 1 = divide, bit 0 = unsigned.
  logic [1:0]          op;
  logic [NB_DATA-1:0]  mag_a;
  logic [NB_DATA-1:0]  mag_b;
  logic [NB_ACC-1:0]   acc;
  logic                neg_res;
  logic                neg_rem;
  logic                div_zero;

  logic                is_mdu_op;
  logic                op_signed;
  logic                accept;
  logic                idle_write;

  logic [NB_DATA:0]    mul_sum;
  logic [NB_ACC-1:0]   mul_next;
  logic [NB_DATA:0]    rem_shift;
  logic [NB_DATA:0]    rem_diff;
  logic                rem_ge;
  logic [NB_ACC-1:0]   div_next;
  logic [NB_ACC-1:0]   prod;
  logic [NB_DATA-1:0]  quo;
  logic [NB_DATA-1:0]  rem;
  logic [NB_DATA-1:0]  fix_hi;
  logic [NB_DATA-1:0]  fix_lo;

  assign is_mdu_op  = (bus.i_control == FUNCT_MULT) || (bus.i_control == FUNCT_MULTU) ||
                      (bus.i_control == FUNCT_DIV)  || (bus.i_control == FUNCT_DIVU);
  assign op_signed  = ~bus.i_control[0];
  assign idle_write = (state == MDU_IDLE) && bus.i_start && !bus.i_flush;
  assign accept     = idle_write && is_mdu_op;

  // NOTE: every variable driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    // Multiply: add the multiplicand into the upper half, then shift the pair right.
    mul_sum  = {1'b0, acc[NB_ACC-1:NB_DATA]} + {1'b0, (mag_b[0] ? mag_a : '0)};
    mul_next = {mul_sum, acc[NB_DATA-1:1]};

    // Divide: upper half is the partial remainder, lower half collects quotient bits.
    rem_shift = {acc[NB_ACC-1:NB_DATA], mag_a[NB_DATA-1]};
    rem_diff  = rem_shift - {1'b0, mag_b};
    rem_ge    = (rem_shift >= {1'b0, mag_b});
    div_next  = {(rem_ge ? rem_diff[NB_DATA-1:0] : rem_shift[NB_DATA-1:0]),
                 acc[NB_DATA-2:0], rem_ge};

    prod = neg_res ? neg64(acc) : acc;
    quo  = acc[NB_DATA-1:0];
    rem  = acc[NB_ACC-1:NB_DATA];

    if (op[1]) begin
      // A zero divisor leaves the dividend magnitude as remainder; re-applying
      // the dividend sign restores the original operand for HI.
      fix_hi = neg_rem ? (~rem + 1'b1) : rem;
      fix_lo = div_zero ? '1 : (neg_res ? (~quo + 1'b1) : quo);
    end else begin
      fix_hi = prod[NB_ACC-1:NB_DATA];
      fix_lo = prod[NB_DATA-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= MDU_IDLE;
      count  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.i_flush) begin
        state <= MDU_IDLE;
        count <= '0;
      end else begin
        unique case (state)
          MDU_IDLE: begin
            if (accept) begin
              state <= MDU_CALC;
              count <= '0;
            end else if (idle_write && bus.i_control == FUNCT_MTHI) begin
              hi_q <= bus.i_op_a;
            end else if (idle_write && bus.i_control == FUNCT_MTLO) begin
              lo_q <= bus.i_op_a;
            end
          end
          MDU_CALC: begin
            count <= count + NB_COUNT'(1);
            if (count == LAST_COUNT) state <= MDU_FIX;
          end
          MDU_FIX: begin
            hi_q   <= fix_hi;
            lo_q   <= fix_lo;
            done_q <= 1'b1;
            state  <= MDU_IDLE;
          end
          default: state <= MDU_IDLE;
        endcase
      end
    end
  end

  // NOTE: datapath registers carry no reset; they are always loaded on accept before use.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      op       <= bus.i_control[1:0];
      mag_a    <= op_signed ? abs32(bus.i_op_a) : bus.i_op_a;
      mag_b    <= op_signed ? abs32(bus.i_op_b) : bus.i_op_b;
      neg_res  <= op_signed & (bus.i_op_a[NB_DATA-1] ^ bus.i_op_b[NB_DATA-1]);
      neg_rem  <= op_signed & bus.i_op_a[NB_DATA-1];
      div_zero <= (bus.i_op_b == '0);
      acc      <= '0;
    end else if (state == MDU_CALC) begin
      if (op[1]) begin
        acc   <= div_next;
        mag_a <= mag_a << 1;
      end else begin
        acc   <= mul_next;
        mag_b <= mag_b >> 1;
      end
    end
  end

  assign bus.o_busy = (state != MDU_IDLE);
  assign bus.o_done = done_q;
  assign bus.o_hi   = hi_q;
  assign bus.o_lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: table of MULT/DIV vectors plus hand-written
// MTxx, flush, ignored-start and mid-op reset sequences.
module tb_mult_div_unit;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mult_div_unit_if #(.NB_DATA(32), .NB_CONTROL(6)) bus ();

  mult_div_unit #(.NB_DATA(32), .NB_CONTROL(6), .NB_COUNT(6)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.i_start   = 1'b0;
    bus.i_flush   = 1'b0;
    bus.i_control = 6'b0;
    bus.i_op_a    = 32'b0;
    bus.i_op_b    = 32'b0;
  endtask

  // Issues one op, counts busy cycles, checks latency, the done pulse and HI/LO.
  // With inject set, a conflicting DIVU is offered on the 5th busy cycle.
  task automatic run_op(input string tag, input logic [5:0] ctrl, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input bit inject);
    int n = 0;
    int early_done = 0;
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_control = ctrl; bus.i_op_a = a; bus.i_op_b = b;
    @(negedge clk);
    idle_inputs();
    while (bus.o_busy && n < 100) begin
      n++;
      if (bus.o_done) early_done++;
      if (inject && n == 5) begin
        bus.i_start = 1'b1; bus.i_control = FUNCT_DIVU;
        bus.i_op_a = 32'd100; bus.i_op_b = 32'd7;
      end else begin
        idle_inputs();
      end
      @(negedge clk);
    end
    idle_inputs();
    check({tag, " busy_cycles"}, 64'(n), 64'd33);
    check({tag, " done_during_busy"}, 64'(early_done), 64'd0);
    check({tag, " done_pulse"}, 64'(bus.o_done), 64'd1);
    check({tag, " hi"}, 64'(bus.o_hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(bus.o_lo), 64'(exp_lo));
    @(negedge clk);
    check({tag, " done_cleared"}, 64'(bus.o_done), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int dones;

    vecs[0] = '{FUNCT_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1] = '{FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{FUNCT_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{FUNCT_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
    vecs[4] = '{FUNCT_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5] = '{FUNCT_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[6] = '{FUNCT_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[7] = '{FUNCT_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[8] = '{FUNCT_DIVU,  32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF};
    vecs[9] = '{FUNCT_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};

    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset hi", 64'(bus.o_hi), 64'd0);
    check("reset lo", 64'(bus.o_lo), 64'd0);
    check("reset busy", 64'(bus.o_busy), 64'd0);
    check("reset done", 64'(bus.o_done), 64'd0);

    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].a, vecs[i].b,
             vecs[i].exp_hi, vecs[i].exp_lo, 1'b0);

    // Back-to-back MTHI then MTLO, each visible the following cycle.
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_control = FUNCT_MTHI; bus.i_op_a = 32'h11;
    @(negedge clk);
    check("mthi hi", 64'(bus.o_hi), 64'h11);
    check("mthi busy", 64'(bus.o_busy), 64'd0);
    bus.i_control = FUNCT_MTLO; bus.i_op_a = 32'h22;
    @(negedge clk);
    idle_inputs();
    check("mtlo lo", 64'(bus.o_lo), 64'h22);
    check("mtlo hi_kept", 64'(bus.o_hi), 64'h11);
    check("mtlo done", 64'(bus.o_done), 64'd0);

    // Flush on the 10th busy cycle of MULT 5x5.
    bus.i_start = 1'b1; bus.i_control = FUNCT_MULT; bus.i_op_a = 32'd5; bus.i_op_b = 32'd5;
    @(negedge clk);
    idle_inputs();
    check("flush busy_started", 64'(bus.o_busy), 64'd1);
    repeat (9) @(negedge clk);
    bus.i_flush = 1'b1;
    @(negedge clk);
    idle_inputs();
    check("flush busy", 64'(bus.o_busy), 64'd0);
    check("flush hi", 64'(bus.o_hi), 64'h11);
    check("flush lo", 64'(bus.o_lo), 64'h22);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.o_done) dones++;
      @(negedge clk);
    end
    check("flush no_done", 64'(dones), 64'd0);

    // Flush wins over a same-cycle MTHI.
    bus.i_start = 1'b1; bus.i_flush = 1'b1; bus.i_control = FUNCT_MTHI; bus.i_op_a = 32'h99;
    @(negedge clk);
    idle_inputs();
    check("flush_mthi hi", 64'(bus.o_hi), 64'h11);

    // A non-MDU code is ignored.
    bus.i_start = 1'b1; bus.i_control = FUNCT_MFHI; bus.i_op_a = 32'h55;
    @(negedge clk);
    idle_inputs();
    check("mfhi busy", 64'(bus.o_busy), 64'd0);
    check("mfhi hi", 64'(bus.o_hi), 64'h11);
    check("mfhi lo", 64'(bus.o_lo), 64'h22);

    // Start offered while busy is ignored: result is 3*4 only.
    run_op("inject", FUNCT_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b1);

    // Reset in the middle of a DIV.
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_control = FUNCT_DIV; bus.i_op_a = 32'hFFFFFFF9; bus.i_op_b = 32'd2;
    @(negedge clk);
    idle_inputs();
    repeat (14) @(negedge clk);
    check("midreset busy_before", 64'(bus.o_busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midreset hi", 64'(bus.o_hi), 64'd0);
    check("midreset lo", 64'(bus.o_lo), 64'd0);
    check("midreset busy", 64'(bus.o_busy), 64'd0);
    check("midreset done", 64'(bus.o_done), 64'd0);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.o_done || bus.o_busy) dones++;
      @(negedge clk);
    end
    check("midreset stays_idle", 64'(dones), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit in the EX stage, beside the ALU. It consumes the same forwarded operands and 6-bit funct-style control code the ALU receives. It owns the architectural HI/LO registers and raises a busy/stall request to the hazard unit while a MULT/DIV is in flight. MFHI/MFLO results are muxed into the EX result path from `o_hi`/`o_lo`.

## Interface
- `NB_DATA`, 32, operand and HI/LO width
- `NB_CONTROL`, 6, control code width (same encoding as ALU funct)
- `NB_COUNT`, 6, iteration counter width (must hold NB_DATA)

- `i_clk` in 1: clock, all state updates on rising edge
- `i_rst` in 1: synchronous, active-high reset
- `i_start` in 1: EX-stage instruction is an MDU op, valid this cycle
- `i_flush` in 1: squash in-flight op (exception or branch flush)
- `i_control` in NB_CONTROL: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010001 MTHI, 010011 MTLO
- `i_op_a` in NB_DATA: rs operand (dividend / multiplicand / MTxx source)
- `i_op_b` in NB_DATA: rt operand (divisor / multiplier)
- `o_hi` out NB_DATA: HI register
- `o_lo` out NB_DATA: LO register
- `o_busy` out 1: stall request, high while state ≠ IDLE
- `o_done` out 1: one-cycle pulse after HI/LO written by MULT/DIV

## Operation
- States: IDLE, CALC, FIX.
- IDLE, `i_start`=1, MULT/MULTU/DIV/DIVU: latch magnitudes (signed ops: two's-complement absolute value), record result signs, clear 64-bit accumulator, counter=0 → CALC.
- IDLE, `i_start`=1, MTHI/MTLO: write `i_op_a` to HI/LO at that edge; stay IDLE; no busy, no done.
- IDLE, `i_start`=1, any other code: ignored.
- CALC, multiply: radix-2 shift-add, one multiplier bit per cycle.
- CALC, divide: restoring division, one quotient bit per cycle.
- CALC: counter increments each cycle. At counter = NB_DATA-1 → FIX.
- FIX: apply signs.
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: quotient negated if signs differ; remainder takes the dividend's sign.
  - Write HI (high product / remainder) and LO (low product / quotient) → IDLE. `o_done`=1 in the following cycle.
- Divide by zero (DIV and DIVU): full latency; HI = `i_op_a` as latched, LO = all ones.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- `i_start` while not IDLE: ignored.
- `i_flush` in any state: → IDLE next edge, HI/LO unchanged, no `o_done`.
- `i_flush` and `i_start` in the same cycle: flush wins, including for MTHI/MTLO.
- Reset (at any time, including mid-op): HI=0, LO=0, state IDLE, `o_busy`=0, `o_done`=0, counter=0.
- Arithmetic widths: product accumulator 2×NB_DATA; divide partial remainder NB_DATA+1 bits. All negation mod 2^NB_DATA or 2^(2·NB_DATA).

## Timing
- Accept edge E0 (IDLE, `i_start`=1).
- CALC occupies the NB_DATA edges E1..E32.
- FIX edge E33 writes HI/LO.
- `o_busy` is high in the cycles after E0 through E33: 33 cycles.
- `o_done` is high for exactly the cycle after E33.
- `o_busy` is combinational from state only, never from `i_start`. The hazard unit stalls an MFHI/MFLO/MTxx/next MDU op while `o_busy`=1.
- `o_hi`/`o_lo` are registered. A value written at edge En is visible in the cycle after En. A back-to-back MTHI→MFHI therefore sees the new value.
- No combinational path from inputs to outputs.

## Structure
- Shared package `mips_pkg`:
  - funct localparams (MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO), also used by the ALU control decode
  - `mdu_state_t` enum
  - `abs32` / `neg64` helper functions
- Single module, no sub-module.
- The multiply and divide datapaths share the accumulator and counter; the op type is a latched 2-bit field.

## Test plan
- MULT, A=0xFFFFFFFD (−3), B=7 → after 33 busy cycles: HI=0xFFFFFFFF, LO=0xFFFFFFEB, one `o_done` pulse.
- MULTU, A=B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV, A=0xFFFFFFF9 (−7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU, A=100, B=0 → LO=0xFFFFFFFF, HI=100 after full latency.
- Flush path:
  - Preload HI=0x11, LO=0x22 via MTHI/MTLO.
  - Start MULT 5×5, assert `i_flush` on the 10th busy cycle → `o_busy`=0 the next cycle, HI=0x11, LO=0x22, no `o_done`.
- Reset path: assert `i_rst` mid-DIV → next cycle HI=LO=0, `o_busy`=0. `i_start` during busy is ignored (results match the first op only).
